// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths and the in-flight tag record
// used by the issue arbiter's tag pipeline.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CTRL_W_DEF = 4;
  localparam int TAG_ID_W   = 2;  // enough for up to 4 requesters

  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_NOP = 4'b0000;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                err;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward, wrapping modulo
// NUM_REQ, and returns a one-hot grant for the first asserted request.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters with round-robin issue and a tag
// pipeline that routes each result back as a one-cycle pulse. Optional macro
// ALU_ARB_CTRL_CHECK_EN rejects illegal control codes and adds the rsp_err output.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int NUM_REQ = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic [DATA_W-1:0]         alu_operand_1,
  output logic [DATA_W-1:0]         alu_operand_2,
  output logic [CTRL_W-1:0]         alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      busy
`ifdef ALU_ARB_CTRL_CHECK_EN
  ,
  output logic                      rsp_err
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(ALU_CTRL_NOP);

  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept_vec;
  logic               accept;
  logic [PTR_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic               sel_err;
  logic [NUM_REQ-1:0] rsp_hit;
  logic               any_tag_valid;

  // Stage 0 is loaded at the accept edge; stage ALU_LAT lines up with alu_result.
  tag_t tag_q [ALU_LAT+1];
  tag_t tag_out;

  assign tag_out = tag_q[ALU_LAT];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign req_ready  = (flush || reset) ? '0 : grant;
  assign accept_vec = req_valid & req_ready;
  assign accept     = |accept_vec;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_vec[i]) grant_idx = PTR_W'(i);
    end
    sel_a    = req_op_a[grant_idx*DATA_W +: DATA_W];
    sel_b    = req_op_b[grant_idx*DATA_W +: DATA_W];
    sel_ctrl = req_ctrl[grant_idx*CTRL_W +: CTRL_W];
`ifdef ALU_ARB_CTRL_CHECK_EN
    sel_err  = (sel_ctrl != CTRL_W'(ALU_CTRL_ADD)) && (sel_ctrl != CTRL_W'(ALU_CTRL_SUB));
`else
    sel_err  = 1'b0;
`endif
    next_ptr = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_hit[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
    end
  end

  always_comb begin
    any_tag_valid = 1'b0;
    for (int k = 0; k <= ALU_LAT; k++) begin
      any_tag_valid = any_tag_valid | tag_q[k].valid;
    end
  end

  assign busy = any_tag_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the tag shift below depends on that ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      alu_ctrl      <= CTRL_NOP;
      for (int k = 0; k <= ALU_LAT; k++) tag_q[k] <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
`ifdef ALU_ARB_CTRL_CHECK_EN
      rsp_err       <= 1'b0;
`endif
    end else if (flush) begin
      // Drop everything in flight; operands, pointer and last response data hold.
      alu_ctrl  <= CTRL_NOP;
      for (int k = 0; k <= ALU_LAT; k++) tag_q[k] <= '0;
      rsp_valid <= '0;
    end else begin
      if (accept) begin
        alu_operand_1 <= sel_a;
        alu_operand_2 <= sel_b;
        alu_ctrl      <= sel_err ? CTRL_NOP : sel_ctrl;
        rr_ptr_q      <= next_ptr;
      end else begin
        alu_ctrl      <= CTRL_NOP;
      end

      tag_q[0].valid <= accept;
      tag_q[0].id    <= TAG_ID_W'(grant_idx);
      tag_q[0].err   <= accept & sel_err;
      for (int k = 1; k <= ALU_LAT; k++) tag_q[k] <= tag_q[k-1];

      rsp_valid <= rsp_hit;
      if (tag_out.valid) begin
        rsp_result <= tag_out.err ? '0 : alu_result;
        rsp_zero   <= !tag_out.err && alu_zero;
`ifdef ALU_ARB_CTRL_CHECK_EN
        rsp_err    <= tag_out.err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural 1-cycle registered ALU;
// exercises ALU_ARB_CTRL_CHECK_EN paths when that macro is defined.
module tb_alu_issue_arbiter;
  import alu_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CTRL_W  = 4;
  localparam int NUM_REQ = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op_a;
  logic [NUM_REQ*DATA_W-1:0] req_op_b;
  logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
  logic [DATA_W-1:0]         alu_operand_1;
  logic [DATA_W-1:0]         alu_operand_2;
  logic [CTRL_W-1:0]         alu_ctrl;
  logic [DATA_W-1:0]         alu_result = '0;
  logic                      alu_zero;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  logic                      busy;
`ifdef ALU_ARB_CTRL_CHECK_EN
  logic                      rsp_err;
`endif

  alu_issue_arbiter #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .NUM_REQ (NUM_REQ),
    .ALU_LAT (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .req_ctrl      (req_ctrl),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_zero      (rsp_zero),
    .busy          (busy)
`ifdef ALU_ARB_CTRL_CHECK_EN
    ,
    .rsp_err       (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: one registered stage, NOP and unknown codes give 0.
  always @(posedge clk) begin
    if (alu_ctrl == ALU_CTRL_ADD)      alu_result <= alu_operand_1 + alu_operand_2;
    else if (alu_ctrl == ALU_CTRL_SUB) alu_result <= alu_operand_1 - alu_operand_2;
    else                               alu_result <= '0;
  end
  assign alu_zero = (alu_result == '0);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c);
    req_op_a[r*DATA_W +: DATA_W] = a;
    req_op_b[r*DATA_W +: DATA_W] = b;
    req_ctrl[r*CTRL_W +: CTRL_W] = c;
  endtask

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ctrl;
    logic [7:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{req: 0, a: 8'h05, b: 8'h03, ctrl: 4'b0010, res: 8'h08, zero: 1'b0};
    vecs[1] = '{req: 1, a: 8'h20, b: 8'h20, ctrl: 4'b0110, res: 8'h00, zero: 1'b1};
    vecs[2] = '{req: 1, a: 8'hFF, b: 8'h02, ctrl: 4'b0010, res: 8'h01, zero: 1'b0};
    vecs[3] = '{req: 0, a: 8'h03, b: 8'h05, ctrl: 4'b0110, res: 8'hFE, zero: 1'b0};
    vecs[4] = '{req: 0, a: 8'h80, b: 8'h80, ctrl: 4'b0010, res: 8'h00, zero: 1'b1};
    vecs[5] = '{req: 1, a: 8'h7F, b: 8'h00, ctrl: 4'b0110, res: 8'h7F, zero: 1'b0};

    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 2'b11;
    req_op_a  = '0;
    req_op_b  = '0;
    req_ctrl  = '0;
    #1;
    check("ready_in_reset", req_ready, 2'b00);
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_result", rsp_result, 8'h00);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_op1", alu_operand_1, 8'h00);
    check("rst_op2", alu_operand_2, 8'h00);
    check("rst_ctrl", alu_ctrl, 4'b0000);
    check("rst_busy", busy, 1'b0);
`ifdef ALU_ARB_CTRL_CHECK_EN
    check("rst_err", rsp_err, 1'b0);
`endif
    req_valid = 2'b00;
    reset     = 1'b0;

    // Single ops, one requester at a time.
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      req_valid = 2'(1 << vecs[i].req);
      #1;
      check($sformatf("v%0d_ready", i), req_ready, 32'(1 << vecs[i].req));
      tick();
      req_valid = 2'b00;
      check($sformatf("v%0d_op1", i), alu_operand_1, vecs[i].a);
      check($sformatf("v%0d_op2", i), alu_operand_2, vecs[i].b);
      check($sformatf("v%0d_ctrl", i), alu_ctrl, vecs[i].ctrl);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      tick();
      check($sformatf("v%0d_early", i), rsp_valid, 2'b00);
      tick();
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, 32'(1 << vecs[i].req));
      check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("v%0d_zero", i), rsp_zero, vecs[i].zero);
`ifdef ALU_ARB_CTRL_CHECK_EN
      check($sformatf("v%0d_err", i), rsp_err, 1'b0);
`endif
      tick();
      check($sformatf("v%0d_pulse_end", i), rsp_valid, 2'b00);
      check($sformatf("v%0d_hold", i), rsp_result, vecs[i].res);
      check($sformatf("v%0d_idle", i), busy, 1'b0);
    end

    // Fairness: both requesters valid continuously for six accepts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 8'h01, 8'h01, 4'b0010);
    set_req(1, 8'h30, 8'h10, 4'b0110);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 2'b11 : 2'b00;
      #1;
      if (c < 6) check($sformatf("rr_grant%0d", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (c >= 2) begin
        check($sformatf("rr_rsp%0d", c - 2), rsp_valid, (c % 2 == 0) ? 2'b01 : 2'b10);
        check($sformatf("rr_res%0d", c - 2), rsp_result, (c % 2 == 0) ? 8'h02 : 8'h20);
      end
    end

    // Flush one cycle after accept; a request held across flush goes next cycle.
    set_req(0, 8'h05, 8'h03, 4'b0010);
    set_req(1, 8'h09, 8'h04, 4'b0110);
    req_valid = 2'b01;
    #1;
    check("fl_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    flush     = 1'b1;
    #1;
    check("fl_ready_during", req_ready, 2'b00);
    tick();
    check("fl_busy", busy, 1'b0);
    check("fl_rsp0", rsp_valid, 2'b00);
    check("fl_ctrl", alu_ctrl, 4'b0000);
    flush = 1'b0;
    #1;
    check("fl_ready_after", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("fl_no_rsp", rsp_valid, 2'b00);
    check("fl_ctrl_sub", alu_ctrl, 4'b0110);
    check("fl_busy2", busy, 1'b1);
    tick();
    check("fl_rsp_gap", rsp_valid, 2'b00);
    tick();
    check("fl_rsp1", rsp_valid, 2'b10);
    check("fl_res1", rsp_result, 8'h05);
    tick();
    check("fl_rsp_end", rsp_valid, 2'b00);

    // Reset with two ops in flight; pointer left at 1 beforehand.
    req_valid = 2'b10;
    tick();
    req_valid = 2'b01;
    tick();
    check("mr_busy", busy, 1'b1);
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mr_ready_rst", req_ready, 2'b00);
    tick();
    check("mr_rsp", rsp_valid, 2'b00);
    check("mr_res", rsp_result, 8'h00);
    check("mr_zero", rsp_zero, 1'b0);
    check("mr_op1", alu_operand_1, 8'h00);
    check("mr_op2", alu_operand_2, 8'h00);
    check("mr_ctrl", alu_ctrl, 4'b0000);
    check("mr_busy0", busy, 1'b0);
    reset = 1'b0;
    #1;
    check("mr_ptr0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("mr_stale0", rsp_valid, 2'b00);
    tick();
    check("mr_stale1", rsp_valid, 2'b00);
    tick();
    check("mr_rsp_new", rsp_valid, 2'b01);
    check("mr_res_new", rsp_result, 8'h08);

`ifdef ALU_ARB_CTRL_CHECK_EN
    // Illegal control code is consumed but never reaches the ALU.
    tick();
    set_req(0, 8'h05, 8'h03, 4'b1111);
    req_valid = 2'b01;
    #1;
    check("ce_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("ce_ctrl", alu_ctrl, 4'b0000);
    check("ce_busy", busy, 1'b1);
    tick();
    tick();
    check("ce_rsp", rsp_valid, 2'b01);
    check("ce_res", rsp_result, 8'h00);
    check("ce_zero", rsp_zero, 1'b0);
    check("ce_err", rsp_err, 1'b1);
    set_req(1, 8'h05, 8'h03, 4'b0010);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    check("ce_ctrl_add", alu_ctrl, 4'b0010);
    tick();
    tick();
    check("ce_rsp2", rsp_valid, 2'b10);
    check("ce_res2", rsp_result, 8'h08);
    check("ce_err2", rsp_err, 1'b0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
